// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: the pipeline (master) reports ID/EX
// instruction info; the controller (slave) returns stage enables, flushes and counters.
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_is_md;
    logic              id_jump;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              pc_we;
    logic              if_id_we;
    logic              if_id_clr;
    logic              id_ex_clr;
    logic              md_busy;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
    logic              md_state;   // debug view of the mul/div FSM: 1 = BUSY

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_jump,
               ex_mem_read, ex_rd, ex_branch_taken,
        input  pc_we, if_id_we, if_id_clr, id_ex_clr, md_busy,
               stall_cnt, flush_cnt, md_state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_jump,
               ex_mem_read, ex_rd, ex_branch_taken,
        output pc_we, if_id_we, if_id_clr, id_ex_clr, md_busy,
               stall_cnt, flush_cnt, md_state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use and mul/div structural
// stalls, branch/jump flushes, plus saturating stall and flush event counters.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_AW     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_ctrl_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    md_state_t   state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        busy_int, lu, mds, stall, accept;
    logic        stall_inc, flush_inc;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        busy_int = (state_q == BUSY);

        lu = bus.ex_mem_read && (bus.ex_rd != REG_AW'(0)) &&
             ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
              (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));
        mds    = busy_int && bus.id_is_md;
        stall  = lu || mds;
        accept = bus.id_is_md && !bus.ex_branch_taken && !stall;

        // A taken branch never aborts BUSY: the mul/div is older than the branch.
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            BUSY: begin
                if (md_cnt_q == 4'd0) state_d = IDLE;
                else                  md_cnt_d = md_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        bus.pc_we     = 1'b1;
        bus.if_id_we  = 1'b1;
        bus.if_id_clr = 1'b0;
        bus.id_ex_clr = 1'b0;
        if (rst) begin
            bus.pc_we     = 1'b0;
            bus.if_id_we  = 1'b0;
            bus.if_id_clr = 1'b1;
            bus.id_ex_clr = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.if_id_clr = 1'b1;
            bus.id_ex_clr = 1'b1;
        end else if (stall) begin
            // A jump waiting in ID is simply held along with everything else.
            bus.pc_we     = 1'b0;
            bus.if_id_we  = 1'b0;
            bus.id_ex_clr = 1'b1;
        end else if (bus.id_jump) begin
            bus.if_id_clr = 1'b1;
        end

        stall_inc     = !rst && !bus.ex_branch_taken && stall;
        flush_inc     = !rst && (bus.ex_branch_taken || (bus.id_jump && !stall));
        bus.md_busy   = busy_int && !rst;
        bus.md_state  = busy_int;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (stall_inc && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_inc && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table of single-cycle cases plus
// hand-written multi-cycle sequences (held jump, mul/div, reset mid-BUSY, saturation).
module tb_hazard_stall_ctrl;
    logic clk;
    logic rst;

    hazard_stall_ctrl_if #(.REG_AW(5)) bus ();

    hazard_stall_ctrl #(.MD_LATENCY(4), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       mem_read;
        logic [4:0] ex_rd;
        logic [4:0] id_rs;
        logic       use_rs;
        logic [4:0] id_rt;
        logic       use_rt;
        logic       is_md;
        logic       jump;
        logic       br;
        logic       pc_we;
        logic       if_id_we;
        logic       if_id_clr;
        logic       id_ex_clr;
        logic       md_busy;
        logic       s_inc;
        logic       f_inc;
    } vec_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_flush = 16'd0;
    vec_t        tbl[11];
    vec_t        v;

    function automatic vec_t mk(
        input string name, input logic r, input logic mr, input logic [4:0] rd,
        input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
        input logic md, input logic j, input logic b,
        input logic pcw, input logic ifw, input logic ifc, input logic idc,
        input logic mbusy, input logic si, input logic fi);
        vec_t t;
        t.name = name; t.rst = r; t.mem_read = mr; t.ex_rd = rd;
        t.id_rs = rs; t.use_rs = urs; t.id_rt = rt; t.use_rt = urt;
        t.is_md = md; t.jump = j; t.br = b;
        t.pc_we = pcw; t.if_id_we = ifw; t.if_id_clr = ifc; t.id_ex_clr = idc;
        t.md_busy = mbusy; t.s_inc = si; t.f_inc = fi;
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t t);
        @(negedge clk);
        rst                 = t.rst;
        bus.ex_mem_read     = t.mem_read;
        bus.ex_rd           = t.ex_rd;
        bus.id_rs           = t.id_rs;
        bus.id_use_rs       = t.use_rs;
        bus.id_rt           = t.id_rt;
        bus.id_use_rt       = t.use_rt;
        bus.id_is_md        = t.is_md;
        bus.id_jump         = t.jump;
        bus.ex_branch_taken = t.br;
        #1;
        check({t.name, ".pc_we"},     16'(bus.pc_we),     16'(t.pc_we));
        check({t.name, ".if_id_we"},  16'(bus.if_id_we),  16'(t.if_id_we));
        check({t.name, ".if_id_clr"}, 16'(bus.if_id_clr), 16'(t.if_id_clr));
        check({t.name, ".id_ex_clr"}, 16'(bus.id_ex_clr), 16'(t.id_ex_clr));
        check({t.name, ".md_busy"},   16'(bus.md_busy),   16'(t.md_busy));
        @(posedge clk);
        #1;
        if (t.rst) begin
            exp_stall = 16'd0;
            exp_flush = 16'd0;
        end else begin
            if (t.s_inc && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (t.f_inc && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
        end
        check({t.name, ".stall_cnt"}, bus.stall_cnt, exp_stall);
        check({t.name, ".flush_cnt"}, bus.flush_cnt, exp_flush);
    endtask

    // Common expected-output shapes
    //            name  rst mr rd rs urs rt urt md j br  pcw ifw ifc idc busy si fi
    initial begin
        tbl[0]  = mk("normal",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk("lu_rs",        0, 1, 8, 8, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = mk("lu_rd0",       0, 1, 0, 0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk("lu_rt",        0, 1, 9, 3, 1, 9, 1, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        tbl[4]  = mk("lu_rs_unused", 0, 1, 8, 8, 0, 2, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk("no_load",      0, 0, 8, 8, 1, 8, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk("branch",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 1);
        tbl[7]  = mk("branch_lu",    0, 1, 8, 8, 1, 0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 1);
        tbl[8]  = mk("jump",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 1);
        tbl[9]  = mk("branch_jump",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 1, 1, 0, 0, 1);
        tbl[10] = mk("jump_lu",      0, 1, 8, 8, 1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0);

        rst = 1'b1;
        bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs = 0; bus.id_use_rs = 0;
        bus.id_rt = 0; bus.id_use_rt = 0; bus.id_is_md = 0; bus.id_jump = 0;
        bus.ex_branch_taken = 0;
        repeat (2) @(posedge clk);

        // Reset state
        apply(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));

        // Single-cycle vector table
        for (int i = 0; i < 11; i++) apply(tbl[i]);

        // Held jump: stalled behind a load-use, then flushes on the next free cycle
        apply(mk("hjump_c1", 0, 1, 8, 8, 1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0));
        apply(mk("hjump_c2", 0, 0, 8, 8, 1, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 1));

        // Mul/div back-to-back: accept c0, busy c1-4 (second op stalls), accept c5, busy c6-9
        apply(mk("md_c0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++)
            apply(mk($sformatf("md_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0));
        apply(mk("md_c5", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        for (int c = 6; c <= 9; c++)
            apply(mk($sformatf("md_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0));
        apply(mk("md_c10", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));

        // Branch does not abort BUSY; reset in BUSY cycle 2 aborts it
        apply(mk("rb_accept", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        apply(mk("rb_branch", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 1, 1, 1, 0, 1));
        apply(mk("rb_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
        apply(mk("rb_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));

        // Saturation: 65540 consecutive load-use stall cycles
        @(negedge clk);
        bus.ex_mem_read = 1; bus.ex_rd = 8; bus.id_rs = 8; bus.id_use_rs = 1;
        repeat (65540) @(posedge clk);
        #1;
        exp_stall = 16'hFFFF;
        check("sat_stall_cnt", bus.stall_cnt, exp_stall);
        apply(mk("sat_hold", 0, 1, 8, 8, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Drives the write-enable and clear inputs of the PC register, the IF/ID register and the ID/EX register. Write-enable holds a stage; clear flushes it to a bubble (all-zero instruction).
- Detects load-use hazards, taken branches (resolved in EX), jumps (resolved in ID) and structural stalls from the multi-cycle multiply/divide unit.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- MD_LATENCY, 4, busy cycles of the mul/div unit after an accepted mul/div issue (legal range 1..15).
- REG_AW, 5, register-index width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- id_rs  input  REG_AW  rs index of the instruction in ID.
- id_rt  input  REG_AW  rt index of the instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_is_md  input  1  ID instruction is mul/div or mfhi/mflo/mthi/mtlo.
- id_jump  input  1  ID instruction is a jump (j/jal/jr).
- ex_mem_read  input  1  EX instruction is a load.
- ex_rd  input  REG_AW  destination index of the EX instruction.
- ex_branch_taken  input  1  branch in EX resolved taken.
- pc_we  output  1  PC write enable.
- if_id_we  output  1  IF/ID write enable.
- if_id_clr  output  1  IF/ID flush.
- id_ex_clr  output  1  ID/EX flush (bubble insertion).
- md_busy  output  1  mul/div unit occupied.
- stall_cnt  output  16  saturating count of stall cycles.
- flush_cnt  output  16  saturating count of flush events.

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. State and counters update on posedge clk.
- Internal conditions:
  - lu = ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - mds = md_busy & id_is_md.
  - stall = lu | mds.
- Priority when conditions coincide: branch > stall > jump > normal.
- Branch (ex_branch_taken=1): pc_we=1, if_id_we=1, if_id_clr=1, id_ex_clr=1. The branch overrides any stall because the ID instruction is squashed. flush_cnt += 1.
- Stall (no branch, stall=1): pc_we=0, if_id_we=0, if_id_clr=0, id_ex_clr=1. stall_cnt += 1. A jump in ID is held and takes effect on the first non-stalled cycle.
- Jump (no branch, no stall, id_jump=1): pc_we=1, if_id_we=1, if_id_clr=1, id_ex_clr=0. flush_cnt += 1.
- Normal: pc_we=1, if_id_we=1, both clears 0.
- Mul/div FSM, states IDLE and BUSY, with a down-counter md_cnt.
  - Accept = id_is_md & !ex_branch_taken & !stall.
  - IDLE -> BUSY on accept; md_cnt <= MD_LATENCY-1. md_busy=1 from the next cycle.
  - In BUSY: md_cnt decrements each cycle. At md_cnt==0 the next state is IDLE.
  - md_busy is asserted for exactly MD_LATENCY cycles after accept.
  - A taken branch does not abort BUSY: the mul/div instruction is older than the branch.
  - An id_is_md instruction in ID during the last BUSY cycle still stalls that cycle. It is accepted on the cycle after, which is IDLE.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset (rst=1, synchronous):
  - State <= IDLE, md_cnt <= 0, stall_cnt <= 0, flush_cnt <= 0.
  - While rst is high: pc_we=0, if_id_we=0, if_id_clr=1, id_ex_clr=1, md_busy=0.
  - Reset during BUSY aborts the operation immediately.
- Zero-register rule: ex_rd==0 never produces a load-use stall.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for one cycle -> pc_we=0, if_id_we=0, id_ex_clr=1 that cycle; stall_cnt 0->1. Same stimulus with ex_rd=0 -> no stall.
- Branch over stall: ex_branch_taken=1 together with the load-use condition -> pc_we=1, if_id_clr=1, id_ex_clr=1; flush_cnt +1; stall_cnt unchanged.
- Held jump: id_jump=1 during load-use cycle -> cycle 1 stalls, if_id_clr=0. Next cycle (lu=0) -> if_id_clr=1, pc_we=1, flush_cnt +1.
- Mul/div back-to-back, MD_LATENCY=4: id_is_md accepted at cycle 0 -> md_busy=1 for cycles 1-4. A second id_is_md held in ID stalls cycles 1-4 (stall_cnt +4) and is accepted at cycle 5, making md_busy=1 for cycles 6-9.
- Reset mid-BUSY: assert rst at cycle 2 of BUSY -> md_busy=0 and counters 0 in the following cycle; while rst is high, clears=1 and write-enables=0.
- Saturation: preload by driving 65540 stall cycles -> stall_cnt holds at 16'hFFFF.
